// File: rtl/rom_rd_arbiter.sv
// Round-robin read arbiter that shares one single-port synchronous ROM among NREQ requesters.
// Each accepted request costs a READ cycle and a CAPT cycle; the captured word returns with a one-hot valid.
module rom_rd_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 4,
    parameter int unsigned DW   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    rsp_valid_o,
    output logic [DW-1:0]      rsp_data_o,
    output logic               rom_r_en_o,
    output logic [AW-1:0]      rom_addr_o,
    input  logic [DW-1:0]      rom_data_i,
    output logic               busy_o
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CAPT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_data_q, rsp_data_d;
    logic              rom_r_en_q, rom_r_en_d;
    logic [AW-1:0]     rom_addr_q, rom_addr_d;
    logic              busy_q, busy_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     win_idx_q, win_idx_d;

    logic              win_found;
    logic [IW-1:0]     win_sel;
    logic [AW-1:0]     win_addr;
    int unsigned       idx;

    // Round-robin search starting at rr_ptr; first requester found wins.
    always_comb begin
        win_found = 1'b0;
        win_sel   = '0;
        win_addr  = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!win_found && req_i[idx]) begin
                win_found = 1'b1;
                win_sel   = IW'(idx);
                win_addr  = req_addr_i[idx*AW +: AW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rom_r_en_q  <= 1'b0;
            rom_addr_q  <= '0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= '0;
            win_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rom_r_en_q  <= rom_r_en_d;
            rom_addr_q  <= rom_addr_d;
            busy_q      <= busy_d;
            rr_ptr_q    <= rr_ptr_d;
            win_idx_q   <= win_idx_d;
        end
    end

    // Next state and next registered outputs; a win launches the READ cycle's outputs.
    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rom_r_en_d  = 1'b0;
        rom_addr_d  = rom_addr_q;
        rr_ptr_d    = rr_ptr_q;
        win_idx_d   = win_idx_q;

        case (state_q)
            IDLE: ;
            READ: state_d = CAPT;
            CAPT: begin
                rsp_data_d             = rom_data_i;
                rsp_valid_d[win_idx_q] = 1'b1;
                state_d                = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if ((state_q == IDLE || state_q == CAPT) && win_found) begin
            state_d          = READ;
            gnt_d[win_sel]   = 1'b1;
            rom_r_en_d       = 1'b1;
            rom_addr_d       = win_addr;
            win_idx_d        = win_sel;
            rr_ptr_d         = IW'((32'(win_sel) + 32'd1) % NREQ);
        end

        busy_d = (state_d != IDLE);
    end

    assign gnt_o       = gnt_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rom_r_en_o  = rom_r_en_q;
    assign rom_addr_o  = rom_addr_q;
    assign busy_o      = busy_q;

endmodule
